// File: rtl/recirc_ctrl_if.sv
// Lane-side bundle for recirc_ctrl: lane inputs, recirculation and downstream
// outputs, plus the idle/state status.
interface recirc_ctrl_if;
    logic [7:0] data_0, data_1, data_2, data_3;
    logic       valid_0, valid_1, valid_2, valid_3;
    logic [7:0] data_0r, data_1r, data_2r, data_3r;
    logic       valid_0r, valid_1r, valid_2r, valid_3r;
    logic [7:0] data_0o, data_1o, data_2o, data_3o;
    logic       valid_0o, valid_1o, valid_2o, valid_3o;
    logic       idle_out;
    logic [1:0] state;

    // master: lane sources / consumers; slave: the controller
    modport master (
        output data_0, data_1, data_2, data_3,
        output valid_0, valid_1, valid_2, valid_3,
        input  data_0r, data_1r, data_2r, data_3r,
        input  valid_0r, valid_1r, valid_2r, valid_3r,
        input  data_0o, data_1o, data_2o, data_3o,
        input  valid_0o, valid_1o, valid_2o, valid_3o,
        input  idle_out, state
    );

    modport slave (
        input  data_0, data_1, data_2, data_3,
        input  valid_0, valid_1, valid_2, valid_3,
        output data_0r, data_1r, data_2r, data_3r,
        output valid_0r, valid_1r, valid_2r, valid_3r,
        output data_0o, data_1o, data_2o, data_3o,
        output valid_0o, valid_1o, valid_2o, valid_3o,
        output idle_out, state
    );
endinterface

// File: rtl/recirc_ctrl.sv
// Sequencing controller for the 4-lane recirculation/demux datapath:
// RESET -> INIT (loopback) -> IDLE <-> ACTIVE (forwarding).
module recirc_lane (
    input  logic       clk_f,
    input  logic       reset,
    input  logic       rec_en_i,
    input  logic       fwd_en_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic [7:0] data_r_o,
    output logic       valid_r_o,
    output logic [7:0] data_o_o,
    output logic       valid_o_o
);
    logic [7:0] data_r_q, data_o_q;
    logic       valid_r_q, valid_o_q;

    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            data_r_q  <= '0;
            valid_r_q <= 1'b0;
            data_o_q  <= '0;
            valid_o_q <= 1'b0;
        end else begin
            data_r_q  <= rec_en_i ? data_i  : '0;
            valid_r_q <= rec_en_i ? valid_i : 1'b0;
            data_o_q  <= fwd_en_i ? data_i  : '0;
            valid_o_q <= fwd_en_i ? valid_i : 1'b0;
        end
    end

    assign data_r_o  = data_r_q;
    assign valid_r_o = valid_r_q;
    assign data_o_o  = data_o_q;
    assign valid_o_o = valid_o_q;
endmodule

module recirc_ctrl #(
    parameter int INIT_CYCLES = 4,
    parameter int IDLE_GAP    = 3
) (
    input  logic       clk_f,
    input  logic       reset,
    recirc_ctrl_if.slave lanes
);
    localparam int NUM_LANES = 4;
    localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES - 1);
    localparam logic [7:0] GAP_LAST  = 8'(IDLE_GAP - 1);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] init_cnt_q, init_cnt_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic       rec_en, fwd_en, any_valid;

    logic [NUM_LANES-1:0][7:0] data, data_r, data_o;
    logic [NUM_LANES-1:0]      valid, valid_r, valid_o;

    assign data  = {lanes.data_3, lanes.data_2, lanes.data_1, lanes.data_0};
    assign valid = {lanes.valid_3, lanes.valid_2, lanes.valid_1, lanes.valid_0};
    assign any_valid = |valid;

    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RESET;
            init_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        rec_en     = 1'b0;
        fwd_en     = 1'b0;
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                rec_en = 1'b1;
                if (init_cnt_q != INIT_LAST) init_cnt_d = init_cnt_q + 8'd1;
                if (init_cnt_q == INIT_LAST && !any_valid) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                // the word that wakes us is forwarded on the same edge
                if (any_valid) begin
                    state_d   = ST_ACTIVE;
                    fwd_en    = 1'b1;
                    gap_cnt_d = '0;
                end
            end
            ST_ACTIVE: begin
                fwd_en = 1'b1;
                if (any_valid) begin
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                    if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        recirc_lane u_lane (
            .clk_f    (clk_f),
            .reset    (reset),
            .rec_en_i (rec_en),
            .fwd_en_i (fwd_en),
            .data_i   (data[i]),
            .valid_i  (valid[i]),
            .data_r_o (data_r[i]),
            .valid_r_o(valid_r[i]),
            .data_o_o (data_o[i]),
            .valid_o_o(valid_o[i])
        );
    end

    assign {lanes.data_3r, lanes.data_2r, lanes.data_1r, lanes.data_0r} = data_r;
    assign {lanes.valid_3r, lanes.valid_2r, lanes.valid_1r, lanes.valid_0r} = valid_r;
    assign {lanes.data_3o, lanes.data_2o, lanes.data_1o, lanes.data_0o} = data_o;
    assign {lanes.valid_3o, lanes.valid_2o, lanes.valid_1o, lanes.valid_0o} = valid_o;
    assign lanes.idle_out = (state_q == ST_IDLE);
    assign lanes.state    = state_q;
endmodule

// File: tb/tb_recirc_ctrl.sv
// Directed bench for recirc_ctrl: reset hold, INIT loopback/exit, forwarding,
// gap timeout and asynchronous mid-operation reset.
module tb_recirc_ctrl;
    logic clk_f = 1'b0;
    logic reset = 1'b0;
    int   n_run = 0, n_fail = 0;

    recirc_ctrl_if lanes ();

    recirc_ctrl #(.INIT_CYCLES(4), .IDLE_GAP(3)) dut (
        .clk_f(clk_f),
        .reset(reset),
        .lanes(lanes)
    );

    always #5 clk_f = ~clk_f;

    logic [31:0] dr, dout;
    logic [3:0]  vr, vo;
    assign dr   = {lanes.data_3r, lanes.data_2r, lanes.data_1r, lanes.data_0r};
    assign dout = {lanes.data_3o, lanes.data_2o, lanes.data_1o, lanes.data_0o};
    assign vr   = {lanes.valid_3r, lanes.valid_2r, lanes.valid_1r, lanes.valid_0r};
    assign vo   = {lanes.valid_3o, lanes.valid_2o, lanes.valid_1o, lanes.valid_0o};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // words packed as {lane3, lane2, lane1, lane0}
    task automatic drive(input logic [3:0] v, input logic [31:0] d);
        {lanes.data_3, lanes.data_2, lanes.data_1, lanes.data_0} = d;
        {lanes.valid_3, lanes.valid_2, lanes.valid_1, lanes.valid_0} = v;
    endtask

    task automatic tick();
        @(posedge clk_f);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out"}, {dr, dout, 24'h0, vr, vo}, 96'h0);
        chk({tag, "_state"}, {30'h0, lanes.state}, 32'd0);
        chk({tag, "_idle"}, {31'h0, lanes.idle_out}, 32'd0);
    endtask

    initial begin
        drive(4'h0, 32'h0);
        // reset hold with random traffic
        for (int i = 0; i < 20; i++) begin
            drive(4'($urandom), $urandom);
            tick();
            if (i % 5 == 4) chk_all_zero("rst_hold");
        end

        drive(4'hf, 32'hccddeeff);
        reset = 1'b1;
        tick();
        chk("rel_state", {30'h0, lanes.state}, 32'd1);
        chk("rel_vr", {28'h0, vr}, 32'h0);

        for (int i = 0; i < 10; i++) begin
            tick();
            chk("init_state", {30'h0, lanes.state}, 32'd1);
            chk("init_dr", dr, 32'hccddeeff);
            chk("init_vr", {28'h0, vr}, 32'hf);
            chk("init_vo", {28'h0, vo}, 32'h0);
            chk("init_idle", {31'h0, lanes.idle_out}, 32'd0);
        end

        drive(4'h0, 32'hccddeeff);
        tick();
        chk("idle_state", {30'h0, lanes.state}, 32'd2);
        chk("idle_out", {31'h0, lanes.idle_out}, 32'd1);
        chk("idle_vr", {28'h0, vr}, 32'h0);
        tick();
        chk("idle_hold", {30'h0, lanes.state}, 32'd2);
        chk("idle_dr", dr, 32'h0);

        drive(4'hf, 32'h8899aabb);
        tick();
        chk("act_state", {30'h0, lanes.state}, 32'd3);
        chk("act_do", dout, 32'h8899aabb);
        chk("act_vo", {28'h0, vo}, 32'hf);
        chk("act_idle", {31'h0, lanes.idle_out}, 32'd0);
        chk("act_vr", {28'h0, vr}, 32'h0);

        drive(4'b0100, 32'h00770000);
        tick();
        chk("l2_do", {24'h0, lanes.data_2o}, 32'h77);
        chk("l2_vo", {28'h0, vo}, 32'b0100);

        drive(4'h0, 32'h0);
        tick();
        chk("gap1", {30'h0, lanes.state}, 32'd3);
        tick();
        chk("gap2", {30'h0, lanes.state}, 32'd3);
        tick();
        chk("gap3", {30'h0, lanes.state}, 32'd2);
        chk("gap3_vo", {28'h0, vo}, 32'h0);

        // valid on the expiring cycle keeps ACTIVE
        drive(4'b0001, 32'h00000011);
        tick();
        chk("re_act", {30'h0, lanes.state}, 32'd3);
        drive(4'h0, 32'h0);
        tick();
        tick();
        drive(4'b1000, 32'h55000000);
        tick();
        chk("late_v_state", {30'h0, lanes.state}, 32'd3);
        chk("late_v_do", dout, 32'h55000000);
        drive(4'h0, 32'h0);
        tick();
        chk("regap1", {30'h0, lanes.state}, 32'd3);
        tick();
        chk("regap2", {30'h0, lanes.state}, 32'd3);
        tick();
        chk("regap3", {30'h0, lanes.state}, 32'd2);

        // asynchronous reset between edges
        drive(4'hf, 32'h01020304);
        tick();
        chk("pre_rst_state", {30'h0, lanes.state}, 32'd3);
        chk("pre_rst_vo", {28'h0, vo}, 32'hf);
        #2 reset = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk_f);
        #1 reset = 1'b1;

        // restart: drop valid after 2 INIT cycles, exit on the 4th
        tick();
        chk("rs_init", {30'h0, lanes.state}, 32'd1);
        tick();
        tick();
        chk("rs_init2", {30'h0, lanes.state}, 32'd1);
        chk("rs_dr", dr, 32'h01020304);
        drive(4'h0, 32'h0);
        tick();
        chk("rs_init3", {30'h0, lanes.state}, 32'd1);
        tick();
        chk("rs_idle", {30'h0, lanes.state}, 32'd2);
        chk("rs_idle_out", {31'h0, lanes.idle_out}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
